// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - detector/tick inputs and lamp/status outputs of the phase scheduler
// master drives tick and detectors; slave is the scheduler itself.
interface traffic_phase_scheduler_if;
   logic       tick;
   logic       det_mt;
   logic       det_s;
   logic [2:0] light_M1;
   logic [2:0] light_M2;
   logic [2:0] light_MT;
   logic [2:0] light_S;
   logic [3:0] phase;
   logic       dem_mt;
   logic       dem_s;
   logic       cycle_done;

   modport master (
      output tick, det_mt, det_s,
      input  light_M1, light_M2, light_MT, light_S, phase, dem_mt, dem_s, cycle_done
   );

   modport slave (
      input  tick, det_mt, det_s,
      output light_M1, light_M2, light_MT, light_S, phase, dem_mt, dem_s, cycle_done
   );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated T-intersection phase scheduler
// Main road rests green; MT and S phases are served only on latched detector demand.
module traffic_phase_scheduler #(
   parameter int MIN_MAIN = 7,
   parameter int T_MT     = 5,
   parameter int T_S      = 3,
   parameter int T_YEL    = 2,
   parameter int T_RED    = 1,
   parameter int TW       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   traffic_phase_scheduler_if.slave  bus
);

   typedef enum logic [3:0] {
      MAIN_G = 4'd0,
      M2_Y   = 4'd1,
      MT_G   = 4'd2,
      MT_Y   = 4'd3,
      MAIN_Y = 4'd4,
      RED1   = 4'd5,
      S_G    = 4'd6,
      S_Y    = 4'd7,
      RED2   = 4'd8
   } state_t;

   localparam logic [2:0] LR = 3'b100;
   localparam logic [2:0] LY = 3'b010;
   localparam logic [2:0] LG = 3'b001;

   // Last timer value of each interval; a zero duration behaves as one tick.
   localparam logic [TW-1:0] L_MAIN = (MIN_MAIN < 1) ? '0 : TW'(MIN_MAIN - 1);
   localparam logic [TW-1:0] L_MT   = (T_MT     < 1) ? '0 : TW'(T_MT - 1);
   localparam logic [TW-1:0] L_S    = (T_S      < 1) ? '0 : TW'(T_S - 1);
   localparam logic [TW-1:0] L_YEL  = (T_YEL    < 1) ? '0 : TW'(T_YEL - 1);
   localparam logic [TW-1:0] L_RED  = (T_RED    < 1) ? '0 : TW'(T_RED - 1);

   state_t          r_state;
   state_t          w_next;
   logic [TW-1:0]   r_timer;
   logic            r_dem_mt;
   logic            r_dem_s;
   logic            r_cycle_done;
   logic [11:0]     r_lamps;
   logic [11:0]     w_lamps;
   logic            w_enter_mt;
   logic            w_enter_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RED2;
         r_timer      <= '0;
         r_dem_mt     <= 1'b0;
         r_dem_s      <= 1'b0;
         r_cycle_done <= 1'b0;
         r_lamps      <= {LR, LR, LR, LR};
      end else begin
         r_state      <= w_next;
         r_lamps      <= w_lamps;
         r_cycle_done <= (w_next == MAIN_G) && (r_state != MAIN_G);
         if (w_next != r_state)
            r_timer <= '0;
         else if (bus.tick && (r_timer != '1))
            r_timer <= r_timer + 1'b1;
         // Entry clear wins; detectors are ignored for the whole served phase.
         if (w_enter_mt)
            r_dem_mt <= 1'b0;
         else if ((r_state != MT_G) && bus.det_mt)
            r_dem_mt <= 1'b1;
         if (w_enter_s)
            r_dem_s <= 1'b0;
         else if ((r_state != S_G) && bus.det_s)
            r_dem_s <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         MAIN_G: if (bus.tick && (r_timer >= L_MAIN) && (r_dem_mt || r_dem_s))
                    w_next = r_dem_mt ? M2_Y : MAIN_Y;
         M2_Y:   if (bus.tick && (r_timer >= L_YEL)) w_next = MT_G;
         MT_G:   if (bus.tick && (r_timer >= L_MT))  w_next = MT_Y;
         MT_Y:   if (bus.tick && (r_timer >= L_YEL)) w_next = RED1;
         MAIN_Y: if (bus.tick && (r_timer >= L_YEL)) w_next = RED1;
         RED1:   if (bus.tick && (r_timer >= L_RED)) w_next = r_dem_s ? S_G : RED2;
         S_G:    if (bus.tick && (r_timer >= L_S))   w_next = S_Y;
         S_Y:    if (bus.tick && (r_timer >= L_YEL)) w_next = RED2;
         RED2:   if (bus.tick && (r_timer >= L_RED)) w_next = MAIN_G;
         default: w_next = RED2;
      endcase
   end

   always_comb begin
      w_lamps = {LR, LR, LR, LR};
      case (w_next)
         MAIN_G:  w_lamps = {LG, LG, LR, LR};
         M2_Y:    w_lamps = {LG, LY, LR, LR};
         MT_G:    w_lamps = {LG, LR, LG, LR};
         MT_Y:    w_lamps = {LY, LR, LY, LR};
         MAIN_Y:  w_lamps = {LY, LY, LR, LR};
         S_G:     w_lamps = {LR, LR, LR, LG};
         S_Y:     w_lamps = {LR, LR, LR, LY};
         default: w_lamps = {LR, LR, LR, LR};
      endcase
   end

   assign w_enter_mt = (w_next == MT_G) && (r_state != MT_G);
   assign w_enter_s  = (w_next == S_G)  && (r_state != S_G);

   assign bus.light_M1   = r_lamps[11:9];
   assign bus.light_M2   = r_lamps[8:6];
   assign bus.light_MT   = r_lamps[5:3];
   assign bus.light_S    = r_lamps[2:0];
   assign bus.phase      = r_state;
   assign bus.dem_mt     = r_dem_mt;
   assign bus.dem_s      = r_dem_s;
   assign bus.cycle_done = r_cycle_done;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
// A plan-queue reference model predicts every clock; a monitor compares on the falling edge.
module tb_traffic_phase_scheduler;

   localparam int MIN_MAIN = 7;
   localparam int T_MT     = 5;
   localparam int T_S      = 3;
   localparam int T_YEL    = 2;
   localparam int T_RED    = 1;

   localparam int P_MAIN_G = 0, P_M2_Y = 1, P_MT_G = 2, P_MT_Y = 3, P_MAIN_Y = 4;
   localparam int P_RED1 = 5, P_S_G = 6, P_S_Y = 7, P_RED2 = 8;

   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

   typedef struct {
      int         ph;
      logic [11:0] lamps;
      logic        dm;
      logic        ds;
      logic        cd;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   bit   started;

   exp_t exp_q[$];
   int   plan[$];
   int   m_ph;
   int   m_ticks;
   bit   m_dm;
   bit   m_ds;

   traffic_phase_scheduler_if u_if ();

   traffic_phase_scheduler #(
      .MIN_MAIN (MIN_MAIN),
      .T_MT     (T_MT),
      .T_S      (T_S),
      .T_YEL    (T_YEL),
      .T_RED    (T_RED),
      .TW       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] lamps_of(input int p);
      case (p)
         P_MAIN_G: return {G, G, R, R};
         P_M2_Y:   return {G, Y, R, R};
         P_MT_G:   return {G, R, G, R};
         P_MT_Y:   return {Y, R, Y, R};
         P_MAIN_Y: return {Y, Y, R, R};
         P_S_G:    return {R, R, R, G};
         P_S_Y:    return {R, R, R, Y};
         default:  return {R, R, R, R};
      endcase
   endfunction

   function automatic int dur(input int p);
      int d;
      case (p)
         P_MAIN_G: d = MIN_MAIN;
         P_MT_G:   d = T_MT;
         P_S_G:    d = T_S;
         P_RED1, P_RED2: d = T_RED;
         default:  d = T_YEL;
      endcase
      return (d < 1) ? 1 : d;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_reset();
      exp_t e;
      e.ph = P_RED2; e.lamps = lamps_of(P_RED2); e.dm = 0; e.ds = 0; e.cd = 0;
      exp_q.push_back(e);
   endtask

   // Reference model: a service plan is drawn up when main yields, extended at RED1.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = P_RED2; m_ticks = 0; m_dm = 0; m_ds = 0;
         plan.delete();
         exp_q.delete();
         push_reset();
      end else begin
         int   nxt;
         exp_t e;
         nxt = m_ph;
         if (u_if.tick) begin
            m_ticks++;
            if (m_ph == P_MAIN_G) begin
               if (m_ticks >= dur(P_MAIN_G) && (m_dm || m_ds)) begin
                  plan.delete();
                  if (m_dm) begin
                     plan.push_back(P_M2_Y); plan.push_back(P_MT_G); plan.push_back(P_MT_Y);
                  end else begin
                     plan.push_back(P_MAIN_Y);
                  end
                  plan.push_back(P_RED1);
                  nxt = plan.pop_front();
               end
            end else if (m_ticks >= dur(m_ph)) begin
               if (m_ph == P_RED1) begin
                  if (m_ds) begin
                     plan.push_back(P_S_G); plan.push_back(P_S_Y);
                  end
                  plan.push_back(P_RED2);
               end
               if (m_ph == P_RED2 || plan.size() == 0) nxt = P_MAIN_G;
               else nxt = plan.pop_front();
            end
         end
         e.cd = (nxt == P_MAIN_G) && (m_ph != P_MAIN_G);
         if (nxt == P_MT_G && m_ph != P_MT_G) m_dm = 0;
         else if (m_ph != P_MT_G && u_if.det_mt) m_dm = 1;
         if (nxt == P_S_G && m_ph != P_S_G) m_ds = 0;
         else if (m_ph != P_S_G && u_if.det_s) m_ds = 1;
         if (nxt != m_ph) m_ticks = 0;
         m_ph = nxt;
         e.ph = m_ph; e.lamps = lamps_of(m_ph); e.dm = m_dm; e.ds = m_ds;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      logic [11:0] act;
      act = {u_if.light_M1, u_if.light_M2, u_if.light_MT, u_if.light_S};
      if (exp_q.size() == 0) begin
         if (started) chk("scoreboard_empty", 1, 0);
      end else begin
         exp_t e;
         started = 1;
         e = exp_q.pop_front();
         chk("phase", int'(u_if.phase), e.ph);
         chk("lamps", int'(act), int'(e.lamps));
         chk("dem_mt", int'(u_if.dem_mt), int'(e.dm));
         chk("dem_s", int'(u_if.dem_s), int'(e.ds));
         chk("cycle_done", int'(u_if.cycle_done), int'(e.cd));
      end
      chk("safe_mt_vs_m2", int'((u_if.light_MT != R) && (u_if.light_M2 != R)), 0);
      chk("safe_s_vs_main",
          int'((u_if.light_S != R) && ((u_if.light_M1 != R) || (u_if.light_M2 != R) || (u_if.light_MT != R))), 0);
      chk("onehot", int'($onehot(u_if.light_M1) && $onehot(u_if.light_M2) &&
                         $onehot(u_if.light_MT) && $onehot(u_if.light_S)), 1);
   end

   task automatic step(input logic t, input logic m, input logic s);
      @(posedge clk);
      #1;
      u_if.tick = t; u_if.det_mt = m; u_if.det_s = s;
   endtask

   // One tick period of four clocks, detectors held at the given levels throughout.
   task automatic tk(input logic m, input logic s);
      step(1'b1, m, s);
      for (int k = 0; k < 3; k++) step(1'b0, m, s);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tk(1'b0, 1'b0);
   endtask

   initial begin
      bit found;
      n_checks = 0; n_errors = 0; started = 0;
      rst = 1'b1;
      u_if.tick = 1'b0; u_if.det_mt = 1'b0; u_if.det_s = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      idle(52);
      chk("idle_rest_main", int'(u_if.phase), P_MAIN_G);

      idle(2); tk(1'b0, 1'b1); idle(20);
      tk(1'b1, 1'b0); idle(25);
      tk(1'b1, 1'b1); idle(30);
      for (int k = 0; k < 40; k++) tk(1'b1, 1'b0);
      idle(30);

      tk(1'b0, 1'b1);
      found = 0;
      for (int k = 0; k < 80 && !found; k++) begin
         if (u_if.phase == 4'(P_S_G)) found = 1;
         else tk(1'b0, 1'b0);
      end
      chk("reach_s_g", int'(found), 1);
      step(1'b1, 1'b1, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("async_lamps", int'({u_if.light_M1, u_if.light_M2, u_if.light_MT, u_if.light_S}),
          int'({R, R, R, R}));
      chk("async_phase", int'(u_if.phase), P_RED2);
      chk("async_dem", int'({u_if.dem_mt, u_if.dem_s}), 0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(20);

      for (int k = 0; k < 3000; k++)
         step(1'(($urandom % 3) == 0), 1'(($urandom % 20) == 0), 1'(($urandom % 25) == 0));

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
